// File: rtl/i2c_cmd_pkg.sv
// Shared command codes, FSM states, phase constants and phase drive table
// for the I2C bit executor.
package i2c_cmd_pkg;

  localparam logic [1:0] CMD_START = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_BIT0  = 2'b00;
  localparam logic [1:0] CMD_BIT1  = 2'b11;

  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic scl_oe;
    logic sda_oe;
  } bus_drive_t;

  // Open-drain pull-down pattern for one quarter of a bus primitive.
  function automatic bus_drive_t phase_drive(input logic [1:0] cmd, input logic [1:0] phase);
    logic [7:0] pat;
    bus_drive_t d;
    pat = 8'h00;
    d   = '0;
    case (cmd)
      CMD_START: pat = 8'b10_00_01_11;
      CMD_STOP:  pat = 8'b11_01_00_00;
      CMD_BIT0:  pat = 8'b11_01_01_11;
      default:   pat = 8'b10_00_00_10;
    endcase
    case (phase)
      P0:      d = bus_drive_t'(pat[7:6]);
      P1:      d = bus_drive_t'(pat[5:4]);
      P2:      d = bus_drive_t'(pat[3:2]);
      default: d = bus_drive_t'(pat[1:0]);
    endcase
    return d;
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-SCL-period divider: tick_c pulses on the last clock of every
// CLK_DIV-clock window; clr restarts the window.
module i2c_quarter_tick #(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_q;

  assign tick_c = (div_q == DIV_W'(CLK_DIV - 1));

  // Divider count, wraps on tick and restarts on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (clr || tick_c) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/i2c_bit_executor.sv
// Bit-level I2C driver: executes one START/STOP/bit primitive per en/is_done
// handshake as four CLK_DIV-long phases on open-drain SCL/SDA.
module i2c_bit_executor
  import i2c_cmd_pkg::*;
#(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] com,
  input  logic       en,
  output logic       is_done,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in,
  output logic       sda_sample,
  output logic       bus_busy
);

  state_e     state_q;
  logic [1:0] cmd_q;
  logic [1:0] phase_q;
  logic       end_q;
  logic       tick_c;
  logic       clr_c;
  logic       is_bit_c;

  assign clr_c    = (state_q != ST_RUN);
  assign is_bit_c = (cmd_q == CMD_BIT0) || (cmd_q == CMD_BIT1);

  i2c_quarter_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_quarter_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr_c),
    .tick_c (tick_c)
  );

  // Command FSM with registered bus drive, handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cmd_q      <= CMD_BIT0;
      phase_q    <= P0;
      end_q      <= 1'b0;
      is_done    <= 1'b0;
      scl_oe     <= 1'b0;
      sda_oe     <= 1'b0;
      sda_sample <= 1'b0;
      bus_busy   <= 1'b0;
    end else begin
      end_q   <= 1'b0;
      is_done <= (state_q == ST_DONE);

      case (state_q)
        ST_IDLE: begin
          if (en) begin
            cmd_q   <= com;
            phase_q <= P0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          {scl_oe, sda_oe} <= phase_drive(cmd_q, phase_q);
          if (tick_c) begin
            phase_q <= phase_q + 2'd1;
            if ((phase_q == P2) && is_bit_c) begin
              sda_sample <= sda_in;
            end
            if (phase_q == P3) begin
              end_q   <= 1'b1;
              state_q <= en ? ST_DONE : ST_IDLE;
            end
          end
        end
        ST_DONE: begin
          if (!en) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Bus ownership follows the completion of START/STOP, aligned with P3 drive.
      if (end_q) begin
        if (cmd_q == CMD_START) begin
          bus_busy <= 1'b1;
        end else if (cmd_q == CMD_STOP) begin
          bus_busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_bit_executor.sv
// Randomized self-checking bench for i2c_bit_executor against a phase-table
// reference model of the bus primitives.
module tb_i2c_bit_executor;

  localparam int CLK_DIV = 4;
  localparam logic [1:0] C_START = 2'b10;
  localparam logic [1:0] C_STOP  = 2'b01;
  localparam logic [1:0] C_BIT0  = 2'b00;
  localparam logic [1:0] C_BIT1  = 2'b11;

  logic       clk;
  logic       rst_n;
  logic [1:0] com;
  logic       en;
  logic       is_done;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_in;
  logic       sda_sample;
  logic       bus_busy;

  int checks;
  int errors;
  int done_cnt;

  // Reference model state: lines held after the last primitive, status bits.
  logic m_scl, m_sda, m_busy, m_sample;

  i2c_bit_executor #(
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .com        (com),
    .en         (en),
    .is_done    (is_done),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe),
    .sda_in     (sda_in),
    .sda_sample (sda_sample),
    .bus_busy   (bus_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {scl_oe, sda_oe} for a primitive in a given quarter period.
  function automatic logic [1:0] drive_of(input logic [1:0] c, input int ph);
    logic [1:0] seq [4];
    case (c)
      C_START: seq = '{2'b10, 2'b00, 2'b01, 2'b11};
      C_STOP:  seq = '{2'b11, 2'b01, 2'b00, 2'b00};
      C_BIT0:  seq = '{2'b11, 2'b01, 2'b01, 2'b11};
      default: seq = '{2'b10, 2'b00, 2'b00, 2'b10};
    endcase
    return seq[ph];
  endfunction

  task automatic model_reset();
    m_scl = 1'b0; m_sda = 1'b0; m_busy = 1'b0; m_sample = 1'b0;
  endtask

  task automatic chk_lines(input string tag, input logic [1:0] exp);
    chk({tag, "_scl"}, 8'(scl_oe), 8'(exp[1]));
    chk({tag, "_sda"}, 8'(sda_oe), 8'(exp[0]));
  endtask

  // One full handshake; optionally drop en during P1.
  task automatic run_cmd(input logic [1:0] cmd, input bit drop_en, input logic sda_lvl);
    logic [1:0] exp_drv;
    int hold;
    @(posedge clk); #1;
    en = 1'b1; com = cmd; sda_in = sda_lvl;
    @(posedge clk);
    @(negedge clk);
    chk_lines("hold", {m_scl, m_sda});
    for (int k = 1; k <= 4 * CLK_DIV; k++) begin
      @(posedge clk); #1;
      if (k == 1) com = 2'($urandom);
      if (drop_en && k == CLK_DIV + 1) en = 1'b0;
      @(negedge clk);
      exp_drv = drive_of(cmd, (k - 1) / CLK_DIV);
      chk_lines("phase", exp_drv);
      chk("done_early", 8'(is_done), 8'd0);
      chk("busy_run", 8'(bus_busy), 8'(m_busy));
    end
    exp_drv = drive_of(cmd, 3);
    m_scl = exp_drv[1];
    m_sda = exp_drv[0];
    if (cmd == C_START) m_busy = 1'b1;
    if (cmd == C_STOP) m_busy = 1'b0;
    if (cmd == C_BIT0 || cmd == C_BIT1) m_sample = sda_lvl;
    @(posedge clk);
    @(negedge clk);
    chk("done", 8'(is_done), drop_en ? 8'd0 : 8'd1);
    if (is_done) done_cnt++;
    chk("busy_end", 8'(bus_busy), 8'(m_busy));
    chk("sample", 8'(sda_sample), 8'(m_sample));
    chk_lines("held", {m_scl, m_sda});
    if (!drop_en) begin
      hold = $urandom_range(0, 3);
      repeat (hold) begin
        @(posedge clk); @(negedge clk);
        chk("done_hold", 8'(is_done), 8'd1);
      end
      @(posedge clk); #1;
      en = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("done_fall_lag", 8'(is_done), 8'd1);
      @(posedge clk); @(negedge clk);
      chk("done_low", 8'(is_done), 8'd0);
    end else begin
      @(posedge clk); @(negedge clk);
      chk("done_never", 8'(is_done), 8'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] byte_v;
    int base;
    checks = 0; errors = 0; done_cnt = 0;
    rst_n = 1'b0; en = 1'b0; com = C_BIT0; sda_in = 1'b1;
    model_reset();

    // Reset and idle bus.
    repeat (3) begin
      @(negedge clk);
      chk_lines("rst", 2'b00);
      chk("rst_done", 8'(is_done), 8'd0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_lines("idle", 2'b00);
      chk("idle_done", 8'(is_done), 8'd0);
      chk("idle_busy", 8'(bus_busy), 8'd0);
    end

    // START, byte 0xA0 MSB first, ACK slot released with slave pulling low.
    run_cmd(C_START, 1'b0, 1'b1);
    base = done_cnt;
    byte_v = 8'hA0;
    for (int i = 7; i >= 0; i--) begin
      run_cmd(byte_v[i] ? C_BIT1 : C_BIT0, 1'b0, 1'($urandom));
    end
    run_cmd(C_BIT1, 1'b0, 1'b0);
    chk("byte_done_cnt", 8'(done_cnt - base), 8'd9);
    chk("ack_sample", 8'(sda_sample), 8'd0);

    // STOP releases the bus and it stays idle.
    run_cmd(C_STOP, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk_lines("stop_idle", 2'b00);
      chk("stop_busy", 8'(bus_busy), 8'd0);
    end

    // en withdrawn mid-command, then a normal command.
    run_cmd(C_START, 1'b0, 1'b1);
    run_cmd(C_BIT0, 1'b1, 1'b1);
    run_cmd(C_BIT1, 1'b0, 1'b1);

    // Random primitives with random sda level and occasional en withdrawal.
    for (int n = 0; n < 24; n++) begin
      run_cmd(2'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
    end

    // Asynchronous reset in the middle of START P2.
    @(posedge clk); #1;
    en = 1'b1; com = C_START;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_lines("async_rst", 2'b00);
    chk("async_rst_done", 8'(is_done), 8'd0);
    chk("async_rst_busy", 8'(bus_busy), 8'd0);
    chk("async_rst_sample", 8'(sda_sample), 8'd0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_cmd(C_START, 1'b0, 1'b1);
    run_cmd(C_STOP, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
